// File: rtl/enemy_bullet_ctrl.sv
// Enemy bullet pool: falling bullets, shot allocation with cooldown,
// per-slot position export and a registered sprite pixel lookup.

// One bullet slot: IDLE/FLY state, position, and pixel coverage test.
module enemy_bullet_slot #(
  parameter int SPEED    = 2,
  parameter int V_BOTTOM = 464,
  parameter int SPRITE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_i,
  input  logic [9:0] spawn_h_i,
  input  logic [9:0] spawn_v_i,
  input  logic       move_tick_i,
  input  logic       hit_clr_i,
  input  logic [9:0] h_cnt_i,
  input  logic [9:0] v_cnt_i,
  output logic       valid_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       cover_o,
  output logic [7:0] addr_o
);
  typedef enum logic {S_IDLE, S_FLY} slot_state_e;

  slot_state_e state_q;
  logic [9:0]  h_q, v_q;
  logic [10:0] v_step;
  logic        exit_bot;

  // 11-bit sum so a bullet near the bottom cannot wrap back to the top
  assign v_step   = {1'b0, v_q} + 11'(SPEED);
  assign exit_bot = v_step > 11'(V_BOTTOM);

  // Slot FSM: allocation loads the spawn point; hit or bottom exit clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (alloc_i) begin
          state_q <= S_FLY;
          h_q     <= spawn_h_i;
          v_q     <= spawn_v_i;
        end
        S_FLY: begin
          if (hit_clr_i || (move_tick_i && exit_bot)) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
          end else if (move_tick_i) begin
            v_q <= v_step[9:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_o = (state_q == S_FLY);
  assign h_o     = h_q;
  assign v_o     = v_q;

  // Coverage window compares are widened so h+SPRITE near 1023 cannot wrap
  assign cover_o = valid_o &&
                   ({1'b0, h_cnt_i} >= {1'b0, h_q}) &&
                   ({1'b0, h_cnt_i} <  ({1'b0, h_q} + 11'(SPRITE))) &&
                   ({1'b0, v_cnt_i} >= {1'b0, v_q}) &&
                   ({1'b0, v_cnt_i} <  ({1'b0, v_q} + 11'(SPRITE)));

  // Only the low nibble of each offset addresses the 16x16 sprite ROM
  assign addr_o = {v_cnt_i[3:0] - v_q[3:0], h_cnt_i[3:0] - h_q[3:0]};
endmodule

module enemy_bullet_ctrl #(
  parameter int N_SLOTS  = 4,
  parameter int SPEED    = 2,
  parameter int V_BOTTOM = 464,
  parameter int SPRITE   = 16,
  parameter int COOLDOWN = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  move_tick,
  input  logic                  fire_req,
  input  logic [9:0]            fire_h,
  input  logic [9:0]            fire_v,
  input  logic [N_SLOTS-1:0]    hit_clr,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  output logic                  fire_ack,
  output logic                  fire_drop,
  output logic [N_SLOTS-1:0]    bullet_valid,
  output logic [10*N_SLOTS-1:0] bullet_h,
  output logic [10*N_SLOTS-1:0] bullet_v,
  output logic                  pix_valid,
  output logic [7:0]            pix_addr
);
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [N_SLOTS-1:0]       valid_w, cover_w, alloc_oh, alloc_w;
  logic [N_SLOTS-1:0][9:0]  h_w, v_w;
  logic [N_SLOTS-1:0][7:0]  addr_w;
  logic                     free_found, fits, accept;
  logic [10:0]              spawn_v;
  logic [CD_W-1:0]          cd_q, cd_d;
  logic                     ack_q, drop_q;
  logic                     pix_hit_d, pix_valid_q;
  logic [7:0]               pix_addr_d, pix_addr_q;

  // Lowest-index IDLE slot from registered state; a slot retiring this
  // cycle still reads FLY here, so it only becomes reusable next cycle
  always_comb begin
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!valid_w[i] && !free_found) begin
        alloc_oh[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign spawn_v = {1'b0, fire_v} + 11'(SPRITE);
  assign fits    = spawn_v <= 11'(V_BOTTOM);
  assign accept  = fire_req && (cd_q == '0) && free_found && fits;
  assign alloc_w = accept ? alloc_oh : '0;

  genvar g;
  generate
    for (g = 0; g < N_SLOTS; g++) begin : g_slot
      enemy_bullet_slot #(
        .SPEED    (SPEED),
        .V_BOTTOM (V_BOTTOM),
        .SPRITE   (SPRITE)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (alloc_w[g]),
        .spawn_h_i   (fire_h),
        .spawn_v_i   (spawn_v[9:0]),
        .move_tick_i (move_tick),
        .hit_clr_i   (hit_clr[g]),
        .h_cnt_i     (h_cnt),
        .v_cnt_i     (v_cnt),
        .valid_o     (valid_w[g]),
        .h_o         (h_w[g]),
        .v_o         (v_w[g]),
        .cover_o     (cover_w[g]),
        .addr_o      (addr_w[g])
      );
    end
  endgenerate

  // Cooldown reloads on an accepted shot, otherwise drains per move_tick
  always_comb begin
    cd_d = cd_q;
    if (accept)
      cd_d = CD_W'(COOLDOWN);
    else if (move_tick && (cd_q != '0))
      cd_d = cd_q - CD_W'(1);
  end

  // Lowest-index covering slot supplies the sprite address
  always_comb begin
    pix_hit_d  = 1'b0;
    pix_addr_d = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (cover_w[i] && !pix_hit_d) begin
        pix_hit_d  = 1'b1;
        pix_addr_d = addr_w[i];
      end
    end
  end

  // Registered cooldown, ack/drop pulses and pixel lookup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_q        <= '0;
      ack_q       <= 1'b0;
      drop_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
    end else begin
      cd_q        <= cd_d;
      ack_q       <= accept;
      drop_q      <= fire_req && !accept;
      pix_valid_q <= pix_hit_d;
      pix_addr_q  <= pix_addr_d;
    end
  end

  assign fire_ack     = ack_q;
  assign fire_drop    = drop_q;
  assign bullet_valid = valid_w;
  assign bullet_h     = h_w;
  assign bullet_v     = v_w;
  assign pix_valid    = pix_valid_q;
  assign pix_addr     = pix_addr_q;
endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Scoreboard bench for enemy_bullet_ctrl: the driver runs an abstract model of
// the bullet pool and queues the expected post-edge outputs; a monitor pops
// and compares after every rising edge.
module tb_enemy_bullet_ctrl;
  localparam int N   = 4;
  localparam int SPD = 2;
  localparam int VB  = 464;
  localparam int SPR = 16;
  localparam int CD  = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            move_tick = 1'b0, fire_req = 1'b0;
  logic [9:0]      fire_h = '0, fire_v = '0, h_cnt = '0, v_cnt = '0;
  logic [N-1:0]    hit_clr = '0;
  logic            fire_ack, fire_drop, pix_valid;
  logic [N-1:0]    bullet_valid;
  logic [10*N-1:0] bullet_h, bullet_v;
  logic [7:0]      pix_addr;

  enemy_bullet_ctrl #(.N_SLOTS(N), .SPEED(SPD), .V_BOTTOM(VB), .SPRITE(SPR), .COOLDOWN(CD)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .fire_req(fire_req),
    .fire_h(fire_h), .fire_v(fire_v), .hit_clr(hit_clr), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .fire_ack(fire_ack), .fire_drop(fire_drop), .bullet_valid(bullet_valid),
    .bullet_h(bullet_h), .bullet_v(bullet_v), .pix_valid(pix_valid), .pix_addr(pix_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            ack;
    logic            drop;
    logic [N-1:0]    vld;
    logic [10*N-1:0] bh;
    logic [10*N-1:0] bv;
    logic            pv;
    logic [7:0]      pa;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;

  // reference model state
  bit   alive[N];
  int   mh[N], mv[N];
  int   cd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compare DUT outputs against the queued expectation after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("ack",   fire_ack,     mon_e.ack);
      chk("drop",  fire_drop,    mon_e.drop);
      chk("valid", bullet_valid, mon_e.vld);
      chk("h",     bullet_h,     mon_e.bh);
      chk("v",     bullet_v,     mon_e.bv);
      chk("pixv",  pix_valid,    mon_e.pv);
      chk("pixa",  pix_addr,     mon_e.pa);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      alive[i] = 0; mh[i] = 0; mv[i] = 0;
    end
    cd = 0;
  endtask

  // one clock of stimulus; the model predicts the outputs after the edge
  task automatic step(input bit f, input int fh, input int fv, input bit mt,
                      input logic [N-1:0] hc, input int hcn, input int vcn);
    exp_t e;
    bit   acc;
    int   slot;
    @(negedge clk);
    fire_req = f; fire_h = 10'(fh); fire_v = 10'(fv);
    move_tick = mt; hit_clr = hc; h_cnt = 10'(hcn); v_cnt = 10'(vcn);
    e = '0;
    // pixel uses positions as they stand before this edge
    for (int i = 0; i < N; i++) begin
      if (!e.pv && alive[i] && hcn >= mh[i] && hcn < mh[i] + SPR &&
          vcn >= mv[i] && vcn < mv[i] + SPR) begin
        e.pv = 1;
        e.pa = 8'(((vcn - mv[i]) % 16) * 16 + ((hcn - mh[i]) % 16));
      end
    end
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!alive[i]) slot = i;
    acc = f && cd == 0 && slot >= 0 && (fv + SPR <= VB);
    e.ack  = acc;
    e.drop = f && !acc;
    for (int i = 0; i < N; i++) begin
      if (alive[i]) begin
        if (hc[i]) begin
          alive[i] = 0; mh[i] = 0; mv[i] = 0;
        end else if (mt) begin
          if (mv[i] + SPD > VB) begin
            alive[i] = 0; mh[i] = 0; mv[i] = 0;
          end else begin
            mv[i] = mv[i] + SPD;
          end
        end
      end
    end
    if (acc) begin
      alive[slot] = 1; mh[slot] = fh; mv[slot] = fv + SPR;
      cd = CD;
    end else if (mt && cd > 0) begin
      cd = cd - 1;
    end
    for (int i = 0; i < N; i++) begin
      e.vld[i]         = alive[i];
      e.bh[i*10 +: 10] = 10'(mh[i]);
      e.bv[i*10 +: 10] = 10'(mv[i]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, '0, 0, 0);
  endtask

  // mid-flight reset: everything must vanish without waiting for a clock edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1; fire_req = 0; move_tick = 0; hit_clr = '0;
    #1;
    chk("rst_valid", bullet_valid, 0);
    chk("rst_ack",   fire_ack, 0);
    chk("rst_drop",  fire_drop, 0);
    chk("rst_pos",   {bullet_h, bullet_v}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  initial begin
    int hcn, vcn, s;
    logic [N-1:0] hc;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("init_valid", bullet_valid, 0);
    chk("init_pos",   {bullet_h, bullet_v}, 0);
    chk("init_pulse", {fire_ack, fire_drop, pix_valid, pix_addr}, 0);

    // first shot lands in slot 0 one sprite below the enemy
    step(1, 100, 50, 0, '0, 0, 0);
    chk("t1_ack", fire_ack, 1);
    chk("t1_vld", bullet_valid, 4'b0001);
    chk("t1_h",   bullet_h[9:0], 100);
    chk("t1_v",   bullet_v[9:0], 66);

    // cooldown: 19 ticks still blocks, 20 ticks frees
    tick(19);
    step(1, 300, 10, 0, '0, 0, 0);
    chk("cd_drop", fire_drop, 1);
    tick(1);
    step(1, 300, 10, 0, '0, 0, 0);
    chk("cd_ack", fire_ack, 1);

    // bottom exit
    do_reset();
    step(1, 0, 446, 0, '0, 0, 0);
    chk("bot_v0", bullet_v[9:0], 462);
    tick(1);
    chk("bot_v1", bullet_v[9:0], 464);
    chk("bot_vld1", bullet_valid[0], 1);
    tick(1);
    chk("bot_vld2", bullet_valid[0], 0);
    chk("bot_pos", {bullet_h[9:0], bullet_v[9:0]}, 0);

    // pool full, then a same-cycle retire is not reusable until next cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 50 * k, 0, 0, '0, 0, 0);
      tick(20);
    end
    step(1, 500, 0, 0, '0, 0, 0);
    chk("full_drop", fire_drop, 1);
    step(1, 500, 0, 0, 4'b0100, 0, 0);
    chk("reuse_drop", fire_drop, 1);
    chk("reuse_vld",  bullet_valid, 4'b1011);
    step(1, 500, 0, 0, '0, 0, 0);
    chk("reuse_ack",  fire_ack, 1);
    chk("reuse_h2",   bullet_h[29:20], 500);

    // pixel lookup on slot 1
    do_reset();
    step(1, 0, 0, 0, '0, 0, 0);
    tick(20);
    step(1, 200, 284, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 203, 305);
    chk("pix_v",  pix_valid, 1);
    chk("pix_a",  pix_addr, 8'h53);
    step(0, 0, 0, 0, '0, 216, 305);
    chk("pix_v0", pix_valid, 0);
    chk("pix_a0", pix_addr, 0);

    // spawn point below the bottom limit
    do_reset();
    step(1, 10, 460, 0, '0, 0, 0);
    chk("low_drop", fire_drop, 1);
    chk("low_vld",  bullet_valid, 0);

    // three in flight with an ack pending, then reset
    do_reset();
    step(1, 10, 0, 0, '0, 0, 0);
    tick(20);
    step(1, 60, 0, 0, '0, 0, 0);
    tick(20);
    step(1, 110, 0, 0, '0, 0, 0);
    chk("pre_rst_vld", bullet_valid, 4'b0111);
    chk("pre_rst_ack", fire_ack, 1);
    do_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      hc = '0;
      for (int i = 0; i < N; i++) hc[i] = ($urandom % 24 == 0);
      s = int'($urandom % N);
      if (alive[s] && ($urandom % 2 == 0)) begin
        hcn = mh[s] + int'($urandom_range(0, 19));
        vcn = mv[s] + int'($urandom_range(0, 19));
        if (hcn >= 2) hcn -= 2;
        if (vcn >= 2) vcn -= 2;
      end else begin
        hcn = int'($urandom % 640);
        vcn = int'($urandom % 480);
      end
      step($urandom % 3 == 0, int'($urandom % 640),
           ($urandom % 8 == 0) ? 440 + int'($urandom % 40) : int'($urandom % 300),
           $urandom % 2 == 1, hc, hcn, vcn);
    end
    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
